// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared FSM state type and instruction field widths.
package pc_sequencer_pkg;
  typedef enum logic [1:0] {WAIT, RUN, HALTED} state_t;
  localparam int JUMP_FIELD_W = 26;
  localparam int IMM_W = 16;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC target computation, priority mux and ROM range check.
module pc_next_sel
  import pc_sequencer_pkg::*;
#(
  parameter int ROM_DEPTH = 16,
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0]         pc,
  input  logic                    halt,
  input  logic                    stall,
  input  logic                    jump,
  input  logic [JUMP_FIELD_W-1:0] jump_tgt,
  input  logic                    branch_taken,
  input  logic [IMM_W-1:0]        branch_off,
  output logic [PC_W-1:0]         next_pc,
  output logic                    load,
  output logic                    oob
);
  logic [PC_W-1:0] pc_plus1, target;
  always_comb begin
    pc_plus1 = pc + PC_W'(1);
    target = jump ? {pc_plus1[PC_W-1:JUMP_FIELD_W], jump_tgt}
           : branch_taken ? pc_plus1 + PC_W'($signed(branch_off))
           : pc_plus1;
    oob = target >= PC_W'(ROM_DEPTH);
    next_pc = oob ? '0 : target;
    load = !halt && !stall;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, retire counter and WAIT/RUN/HALTED control FSM
// feeding an external instruction ROM.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ROM_DEPTH = 16,
  parameter int PC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    halt,
  input  logic                    branch_taken,
  input  logic [IMM_W-1:0]        branch_off,
  input  logic                    jump,
  input  logic [JUMP_FIELD_W-1:0] jump_tgt,
  output logic [PC_W-1:0]         index,
  output logic                    fetch_valid,
  output logic [31:0]             retired_cnt,
  output logic                    pc_oob
);
  state_t state, state_nx;
  logic [PC_W-1:0] next_pc;
  logic load, oob, adv;
  pc_next_sel #(.ROM_DEPTH(ROM_DEPTH), .PC_W(PC_W)) u_sel (
    .pc(index),
    .halt(halt),
    .stall(stall),
    .jump(jump),
    .jump_tgt(jump_tgt),
    .branch_taken(branch_taken),
    .branch_off(branch_off),
    .next_pc(next_pc),
    .load(load),
    .oob(oob)
  );
  always_comb begin
    state_nx = state == WAIT ? RUN : (state == RUN && halt) ? HALTED : state;
    fetch_valid = state == RUN;
    adv = fetch_valid && load;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      index <= '0;
      retired_cnt <= '0;
      pc_oob <= 1'b0;
    end else begin
      state <= state_nx;
      if (adv) begin
        index <= next_pc;
        retired_cnt <= retired_cnt + 32'd1;
        if (oob) pc_oob <= 1'b1;
      end
    end
  end
endmodule
